aaf_stage_scheduler: RTL and testbench

Sequences the two-stage serial anti-aliasing filter chain from the input sample strobe. It issues the stage-1 serial FIR clock-enable burst for every input sample and counts stage-1 outputs for the decimation boundary. On each boundary it issues the stage-2 serial FIR burst and flags the decimated output. It replaces the ad-hoc free-running enable counters and start latch with one deterministic scheduler that detects overruns.

---
 rtl/aaf_sched_pkg.sv | 28 ++
 rtl/aaf_burst_gen.sv | 93 +++++++++
 rtl/aaf_stage_scheduler.sv | 125 ++++++++++++
 tb/tb_aaf_stage_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/aaf_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aaf_sched_pkg
// Description : Shared constants, engine state type and counter-width helper
//               for the anti-aliasing filter stage scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package aaf_sched_pkg;

  localparam int unsigned C_FIR1_PHASES    = 28;
  localparam int unsigned C_FIR1_EN_PERIOD = 55;
  localparam int unsigned C_DECIM          = 8;
  localparam int unsigned C_FIR2_PHASES    = 28;
  localparam int unsigned C_FIR2_EN_PERIOD = 55;
  localparam int unsigned C_OVR_CNT_W      = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } eng_state_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aaf_burst_gen.sv
`default_nettype none
// ============================================================================
// Module      : aaf_burst_gen
// Description : Single serial-FIR burst engine. A trigger while idle issues
//               PHASES enable pulses spaced EN_PERIOD clocks apart, flags the
//               final one, then pulses done. Triggers while running are
//               reported as drops and otherwise ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module aaf_burst_gen
  import aaf_sched_pkg::*;
#(
  parameter int unsigned PHASES    = C_FIR1_PHASES,
  parameter int unsigned EN_PERIOD = C_FIR1_EN_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  output logic en_o,
  output logic last_o,
  output logic done_o,
  output logic busy_o,
  output logic drop_o
);

  localparam int unsigned PW = cnt_w(PHASES);
  localparam int unsigned GW = cnt_w(EN_PERIOD);
  localparam logic [PW-1:0] LAST_PH = PW'(PHASES - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(EN_PERIOD - 1);

  eng_state_e    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_q, done_d;
  logic          fire;
  logic          final_en;

  // Next-state logic: enables fire at gap 0, the last phase returns to idle.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    fire     = 1'b0;
    final_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_i) begin
          state_d = ST_RUN;
          phase_d = '0;
          gap_d   = '0;
        end
      end
      ST_RUN: begin
        fire     = (gap_q == '0);
        final_en = fire && (phase_q == LAST_PH);
        if (final_en) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (gap_q == GAP_MAX) begin
          gap_d   = '0;
          phase_d = phase_q + 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  assign en_o   = fire;
  assign last_o = final_en;
  assign done_o = done_q;
  assign busy_o = (state_q == ST_RUN);
  assign drop_o = trig_i && (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: rtl/aaf_stage_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : aaf_stage_scheduler
// Description : Two-stage anti-aliasing filter scheduler. Each accepted input
//               sample launches a stage-1 burst; every DECIM stage-1 results
//               launch a stage-2 burst. Dropped samples and dropped stage-2
//               triggers are flagged and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module aaf_stage_scheduler
  import aaf_sched_pkg::*;
#(
  parameter int unsigned FIR1_PHASES    = C_FIR1_PHASES,
  parameter int unsigned FIR1_EN_PERIOD = C_FIR1_EN_PERIOD,
  parameter int unsigned DECIM          = C_DECIM,
  parameter int unsigned FIR2_PHASES    = C_FIR2_PHASES,
  parameter int unsigned FIR2_EN_PERIOD = C_FIR2_EN_PERIOD,
  parameter int unsigned OVR_CNT_W      = C_OVR_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   sample_valid_i,
  input  logic                   clr_ovr_i,
  output logic                   fir1_en_o,
  output logic                   fir1_last_o,
  output logic                   fir1_done_o,
  output logic [$clog2(DECIM):0] decim_phase_o,
  output logic                   fir2_en_o,
  output logic                   fir2_last_o,
  output logic                   out_valid_o,
  output logic                   busy_o,
  output logic                   ovr1_o,
  output logic                   ovr2_o,
  output logic [OVR_CNT_W-1:0]   ovr_cnt_o
);

  localparam int unsigned DPW = $clog2(DECIM) + 1;
  localparam int unsigned SW  = OVR_CNT_W + 1;
  localparam logic [DPW-1:0] DP_LAST = DPW'(DECIM - 1);

  logic                 trig1, trig2;
  logic                 done1, busy1, busy2, drop1, drop2;
  logic [DPW-1:0]       dp_q, dp_d;
  logic                 ovr1_q, ovr1_d, ovr2_q, ovr2_d;
  logic [OVR_CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [SW-1:0]        cnt_sum;

  assign trig1 = sample_valid_i & enable_i;

  aaf_burst_gen #(
    .PHASES    (FIR1_PHASES),
    .EN_PERIOD (FIR1_EN_PERIOD)
  ) u_stage1 (
    .clk    (clk),
    .rst    (rst),
    .trig_i (trig1),
    .en_o   (fir1_en_o),
    .last_o (fir1_last_o),
    .done_o (done1),
    .busy_o (busy1),
    .drop_o (drop1)
  );

  aaf_burst_gen #(
    .PHASES    (FIR2_PHASES),
    .EN_PERIOD (FIR2_EN_PERIOD)
  ) u_stage2 (
    .clk    (clk),
    .rst    (rst),
    .trig_i (trig2),
    .en_o   (fir2_en_o),
    .last_o (fir2_last_o),
    .done_o (out_valid_o),
    .busy_o (busy2),
    .drop_o (drop2)
  );

  // Decimation counter: the wrap on a stage-1 result fires stage 2 the same cycle.
  always_comb begin
    dp_d  = dp_q;
    trig2 = 1'b0;
    if (done1) begin
      if (dp_q == DP_LAST) begin
        dp_d  = '0;
        trig2 = 1'b1;
      end else begin
        dp_d = dp_q + 1'b1;
      end
    end
  end

  // Overrun flags and saturating counter; a new event beats a coincident clear.
  always_comb begin
    ovr1_d   = (ovr1_q & ~clr_ovr_i) | drop1;
    ovr2_d   = (ovr2_q & ~clr_ovr_i) | drop2;
    cnt_base = clr_ovr_i ? '0 : cnt_q;
    cnt_sum  = {1'b0, cnt_base} + SW'(drop1) + SW'(drop2);
    cnt_d    = cnt_sum[SW-1] ? '1 : cnt_sum[OVR_CNT_W-1:0];
  end

  // Decimation and overrun registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_q   <= '0;
      ovr1_q <= 1'b0;
      ovr2_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dp_q   <= dp_d;
      ovr1_q <= ovr1_d;
      ovr2_q <= ovr2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fir1_done_o   = done1;
  assign decim_phase_o = dp_q;
  assign busy_o        = busy1 | busy2;
  assign ovr1_o        = ovr1_q;
  assign ovr2_o        = ovr2_q;
  assign ovr_cnt_o     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aaf_stage_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_aaf_stage_scheduler
// Description : Bench for aaf_stage_scheduler. Two instances (DECIM=2 and
//               DECIM=1) share stimulus; outputs are compared every cycle
//               with a model that derives pulse times from trigger times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aaf_stage_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, enable = 1'b0, sample_valid = 1'b0, clr_ovr = 1'b0;

  logic       a_f1en, a_f1last, a_f1done, a_f2en, a_f2last, a_ov, a_busy, a_o1, a_o2;
  logic [1:0] a_dp;
  logic [2:0] a_cnt;
  logic       b_f1en, b_f1last, b_f1done, b_f2en, b_f2last, b_ov, b_busy, b_o1, b_o2;
  logic [0:0] b_dp;
  logic [2:0] b_cnt;

  aaf_stage_scheduler #(
    .FIR1_PHASES(4), .FIR1_EN_PERIOD(3), .DECIM(2),
    .FIR2_PHASES(3), .FIR2_EN_PERIOD(5), .OVR_CNT_W(3)
  ) u_dut_a (
    .clk(clk), .rst(rst), .enable_i(enable), .sample_valid_i(sample_valid),
    .clr_ovr_i(clr_ovr), .fir1_en_o(a_f1en), .fir1_last_o(a_f1last),
    .fir1_done_o(a_f1done), .decim_phase_o(a_dp), .fir2_en_o(a_f2en),
    .fir2_last_o(a_f2last), .out_valid_o(a_ov), .busy_o(a_busy),
    .ovr1_o(a_o1), .ovr2_o(a_o2), .ovr_cnt_o(a_cnt)
  );

  aaf_stage_scheduler #(
    .FIR1_PHASES(4), .FIR1_EN_PERIOD(3), .DECIM(1),
    .FIR2_PHASES(3), .FIR2_EN_PERIOD(6), .OVR_CNT_W(3)
  ) u_dut_b (
    .clk(clk), .rst(rst), .enable_i(enable), .sample_valid_i(sample_valid),
    .clr_ovr_i(clr_ovr), .fir1_en_o(b_f1en), .fir1_last_o(b_f1last),
    .fir1_done_o(b_f1done), .decim_phase_o(b_dp), .fir2_en_o(b_f2en),
    .fir2_last_o(b_f2last), .out_valid_o(b_ov), .busy_o(b_busy),
    .ovr1_o(b_o1), .ovr2_o(b_o2), .ovr_cnt_o(b_cnt)
  );

  int     n_total = 0;
  int     n_bad   = 0;
  longint cyc     = 0;

  // Model configuration per instance
  longint m_ph1[2]  = '{4, 4};
  longint m_per1[2] = '{3, 3};
  longint m_dec[2]  = '{2, 1};
  longint m_ph2[2]  = '{3, 3};
  longint m_per2[2] = '{5, 6};
  localparam int CNT_MAX = 7;

  // Model state: last accepted trigger time per engine, decimation, overruns
  bit     m_v1[2]  = '{0, 0};
  bit     m_v2[2]  = '{0, 0};
  longint m_t1[2]  = '{0, 0};
  longint m_t2[2]  = '{0, 0};
  longint m_dp[2]  = '{0, 0};
  bit     m_o1[2]  = '{0, 0};
  bit     m_o2[2]  = '{0, 0};
  int     m_cnt[2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit in_run(bit v, longint t, longint ph, longint per, longint c);
    return v && (c >= t + 1) && (c <= t + 1 + (ph - 1) * per);
  endfunction

  function automatic bit is_en(bit v, longint t, longint ph, longint per, longint c);
    return in_run(v, t, ph, per, c) && (((c - t - 1) % per) == 0);
  endfunction

  function automatic bit is_last(bit v, longint t, longint ph, longint per, longint c);
    return is_en(v, t, ph, per, c) && (((c - t - 1) / per) == ph - 1);
  endfunction

  function automatic bit is_done(bit v, longint t, longint ph, longint per, longint c);
    return v && (c == t + 2 + (ph - 1) * per);
  endfunction

  function automatic logic [8:0] exp_ctl(int d, longint c);
    return {is_en  (m_v1[d], m_t1[d], m_ph1[d], m_per1[d], c),
            is_last(m_v1[d], m_t1[d], m_ph1[d], m_per1[d], c),
            is_done(m_v1[d], m_t1[d], m_ph1[d], m_per1[d], c),
            is_en  (m_v2[d], m_t2[d], m_ph2[d], m_per2[d], c),
            is_last(m_v2[d], m_t2[d], m_ph2[d], m_per2[d], c),
            is_done(m_v2[d], m_t2[d], m_ph2[d], m_per2[d], c),
            in_run(m_v1[d], m_t1[d], m_ph1[d], m_per1[d], c) |
            in_run(m_v2[d], m_t2[d], m_ph2[d], m_per2[d], c),
            m_o1[d], m_o2[d]};
  endfunction

  // Advance the model by one cycle given the inputs present in cycle c.
  task automatic model_update(input longint c, input bit r, input bit en,
                              input bit sv, input bit clr);
    bit r1, r2, dn1, d1, d2, tr2;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_v1[d] = 0; m_v2[d] = 0; m_dp[d] = 0;
        m_o1[d] = 0; m_o2[d] = 0; m_cnt[d] = 0;
      end else begin
        r1  = in_run(m_v1[d], m_t1[d], m_ph1[d], m_per1[d], c);
        dn1 = is_done(m_v1[d], m_t1[d], m_ph1[d], m_per1[d], c);
        r2  = in_run(m_v2[d], m_t2[d], m_ph2[d], m_per2[d], c);
        d1  = sv && en && r1;
        if (sv && en && !r1) begin m_v1[d] = 1; m_t1[d] = c; end
        tr2 = 0;
        if (dn1) begin
          if (m_dp[d] == m_dec[d] - 1) begin m_dp[d] = 0; tr2 = 1; end
          else m_dp[d] = m_dp[d] + 1;
        end
        d2 = tr2 && r2;
        if (tr2 && !r2) begin m_v2[d] = 1; m_t2[d] = c; end
        m_o1[d]  = (clr ? 1'b0 : m_o1[d]) | d1;
        m_o2[d]  = (clr ? 1'b0 : m_o2[d]) | d2;
        m_cnt[d] = (clr ? 0 : m_cnt[d]) + int'(d1) + int'(d2);
        if (m_cnt[d] > CNT_MAX) m_cnt[d] = CNT_MAX;
      end
    end
  endtask

  // One clock: check outputs of the new cycle, then drive and model its inputs.
  task automatic step(input bit r, input bit en, input bit sv, input bit clr);
    @(posedge clk);
    #1;
    cyc++;
    chk("A.ctl", 32'({a_f1en, a_f1last, a_f1done, a_f2en, a_f2last, a_ov, a_busy, a_o1, a_o2}),
        32'(exp_ctl(0, cyc)));
    chk("A.dp",  32'(a_dp),  32'(m_dp[0]));
    chk("A.cnt", 32'(a_cnt), 32'(m_cnt[0]));
    chk("B.ctl", 32'({b_f1en, b_f1last, b_f1done, b_f2en, b_f2last, b_ov, b_busy, b_o1, b_o2}),
        32'(exp_ctl(1, cyc)));
    chk("B.dp",  32'(b_dp),  32'(m_dp[1]));
    chk("B.cnt", 32'(b_cnt), 32'(m_cnt[1]));
    rst = r; enable = en; sample_valid = sv; clr_ovr = clr;
    model_update(cyc, r, en, sv, clr);
  endtask

  // Reset at offset 0, then samples/reset/clear at the given offsets.
  task automatic run_seg(input int len, input int sv_a, input int sv_b,
                         input int rst_at, input int clr_at, input bit en);
    for (int i = 0; i < len; i++)
      step(i == 0 || i == rst_at, en, i == sv_a || i == sv_b, i == clr_at);
  endtask

  initial begin
    // Power-on reset is driven at time 0; the model starts in the reset state.
    run_seg(80, 10, 30, -1, -1, 1'b1);   // two samples, decimation wrap, stage 2
    run_seg(60, 10, 15, -1, 25, 1'b1);   // stage-1 overrun then clear
    run_seg(80, 10, 30, 16, -1, 1'b1);   // reset mid-burst, restart
    run_seg(80, 10, 21, -1, -1, 1'b1);   // sample in the done cycle; B drops stage 2
    run_seg(40, 10, -1, -1, -1, 1'b0);   // enable low
    run_seg(40, 10, 12, -1, 12, 1'b1);   // clear coinciding with an overrun
    for (int i = 0; i < 4000; i++)
      step(i == 0 || $urandom_range(0, 599) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 149) == 0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
